// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: fetch stage between the PC and decode.
// Issues one req/ack instruction read at a time, buffers {pc, instr} pairs in a
// DEPTH-entry FIFO, and releases the PC (pc_hold=0) once per accepted fetch.
// A flush discards the buffered entries and any read still in flight.
// Optional feature macro: IFQ_BYPASS_EN (ack-to-decode combinational bypass
// when the FIFO is empty).
module instr_fetch_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_addr,
  output logic              pc_hold,
  input  logic              flush,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic [CW-1:0]     count
);

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t                         state_q, state_d;
  logic [ADDR_W-1:0]              req_pc_q, req_pc_d;
  logic [CW-1:0]                  count_q, count_d;
  logic [PW-1:0]                  wr_q, rd_q;
  logic [DEPTH-1:0][DATA_W-1:0]   instr_q;
  logic [DEPTH-1:0][ADDR_W-1:0]   pc_q;

  logic ack_ok;    // ack for a live (non-flushed) request
  logic push;      // write returned pair into the FIFO
  logic pop;       // decode consumes a buffered head entry
  logic byp_take;  // returned pair consumed straight from memory

  assign ack_ok = (state_q == WAIT) && mem_ack && !flush;
  assign pop    = (count_q != '0) && out_ready && !flush;

`ifdef IFQ_BYPASS_EN
  logic byp;
  assign byp       = ack_ok && (count_q == '0);
  assign byp_take  = byp && out_ready;
  assign out_valid = (count_q != '0) || byp;
  assign out_instr = byp ? mem_rdata : instr_q[rd_q];
  assign out_pc    = byp ? req_pc_q  : pc_q[rd_q];
`else
  assign byp_take  = 1'b0;
  assign out_valid = (count_q != '0);
  assign out_instr = instr_q[rd_q];
  assign out_pc    = pc_q[rd_q];
`endif

  assign push     = ack_ok && !byp_take;
  assign count_d  = count_q + CW'(push) - CW'(pop);
  assign count    = count_q;
  assign mem_req  = (state_q != IDLE);
  assign mem_addr = req_pc_q;
  // PC advances only when a live fetch completes (pushed or bypassed)
  assign pc_hold  = !ack_ok;

  // Next-state: one outstanding request; flushed reads are drained in DROP
  always_comb begin
    state_d  = state_q;
    req_pc_d = req_pc_q;
    unique case (state_q)
      IDLE: if (!flush && (count_q < CW'(DEPTH))) begin
        req_pc_d = pc_addr;
        state_d  = WAIT;
      end
      WAIT: begin
        if (flush)        state_d = mem_ack ? IDLE : DROP;
        else if (mem_ack) state_d = IDLE;
      end
      DROP: if (mem_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM and request address registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      req_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      req_pc_q <= req_pc_d;
    end
  end

  // FIFO storage, pointers and occupancy; flush empties it and drops push/pop
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      instr_q <= '0;
      pc_q    <= '0;
    end else if (flush) begin
      count_q <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
    end else begin
      if (push) begin
        instr_q[wr_q] <= mem_rdata;
        pc_q[wr_q]    <= req_pc_q;
        wr_q          <= wr_q + PW'(1);
      end
      if (pop) rd_q <= rd_q + PW'(1);
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue (DEPTH=4, 32-bit address/data).
// Inputs change 1ns after the rising edge; outputs are checked before the next edge.
module tb_instr_fetch_queue;
  logic        clock = 1'b0;
  logic        reset, flush, mem_ack, out_ready;
  logic [31:0] pc_addr, mem_rdata;
  logic        pc_hold, mem_req, out_valid;
  logic [31:0] mem_addr, out_instr, out_pc;
  logic [2:0]  count;
  int n_chk = 0;
  int n_fail = 0;

  instr_fetch_queue #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clock(clock), .reset(reset), .pc_addr(pc_addr), .pc_hold(pc_hold),
    .flush(flush), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .count(count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic fetch(input logic [31:0] data, input logic [2:0] exp_cnt);
    logic [31:0] a;
    a = pc_addr;
    tick();
    chk("fetch_req", mem_req, 1'b1);
    chk("fetch_addr", mem_addr, a);
    mem_ack = 1'b1; mem_rdata = data;
    #1;
    chk("fetch_hold_low", pc_hold, 1'b0);
    tick();
    mem_ack = 1'b0;
    pc_addr = pc_addr + 32'd1;
    #1;
    chk("fetch_cnt", count, exp_cnt);
    chk("fetch_hold_high", pc_hold, 1'b1);
    chk("fetch_req_drop", mem_req, 1'b0);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; mem_ack = 1'b0; out_ready = 1'b0;
    pc_addr = 32'd0; mem_rdata = 32'd0;

    tick(); tick();
    chk("rst_req", mem_req, 1'b0);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_hold", pc_hold, 1'b1);
    chk("rst_cnt", count, 3'd0);
    chk("rst_pc", out_pc, 32'd0);
    chk("rst_instr", out_instr, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);

    reset = 1'b0; out_ready = 1'b1;
    fetch(32'h100, 3'd1);
    chk("t2_pc0", out_pc, 32'd0);
    chk("t2_in0", out_instr, 32'h100);
    chk("t2_v0", out_valid, 1'b1);
    fetch(32'h101, 3'd1);
    chk("t2_pc1", out_pc, 32'd1);
    chk("t2_in1", out_instr, 32'h101);
    fetch(32'h102, 3'd1);
    chk("t2_pc2", out_pc, 32'd2);
    chk("t2_in2", out_instr, 32'h102);

    out_ready = 1'b0;
    fetch(32'h103, 3'd2);
    fetch(32'h104, 3'd3);
    fetch(32'h105, 3'd4);
    tick();
    chk("t3_full_req", mem_req, 1'b0);
    chk("t3_full_hold", pc_hold, 1'b1);
    chk("t3_full_cnt", count, 3'd4);
    chk("t3_head", out_pc, 32'd2);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    #1;
    chk("t3_pop_cnt", count, 3'd3);
    chk("t3_pop_head", out_pc, 32'd3);
    chk("t3_pop_instr", out_instr, 32'h103);
    tick();
    chk("t3_reissue", mem_req, 1'b1);
    chk("t3_reissue_addr", mem_addr, 32'd6);

    flush = 1'b1; pc_addr = 32'd213;
    #1;
    chk("t4_flush_hold", pc_hold, 1'b1);
    tick();
    flush = 1'b0;
    #1;
    chk("t4_drop_req", mem_req, 1'b1);
    chk("t4_drop_addr", mem_addr, 32'd6);
    chk("t4_flush_cnt", count, 3'd0);
    chk("t4_flush_valid", out_valid, 1'b0);
    tick();
    chk("t4_drop_req2", mem_req, 1'b1);
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    #1;
    chk("t4_drop_hold", pc_hold, 1'b1);
    tick();
    mem_ack = 1'b0;
    #1;
    chk("t4_no_push", count, 3'd0);
    chk("t4_idle", mem_req, 1'b0);
    tick();
    chk("t4_new_addr", mem_addr, 32'd213);
    mem_ack = 1'b1; mem_rdata = 32'h213;
    tick();
    mem_ack = 1'b0; pc_addr = 32'd214;
    #1;
    chk("t4_new_cnt", count, 3'd1);
    chk("t4_new_pc", out_pc, 32'd213);

    fetch(32'h214, 3'd2);
    tick();
    chk("t5_req", mem_req, 1'b1);
    chk("t5_addr", mem_addr, 32'd215);
    mem_ack = 1'b1; mem_rdata = 32'h215; flush = 1'b1;
    #1;
    chk("t5_hold", pc_hold, 1'b1);
    tick();
    mem_ack = 1'b0; flush = 1'b0;
    #1;
    chk("t5_cnt", count, 3'd0);
    chk("t5_valid", out_valid, 1'b0);
    chk("t5_req_idle", mem_req, 1'b0);

    out_ready = 1'b1;
    tick();
    chk("t6_addr", mem_addr, 32'd215);
    mem_ack = 1'b1; mem_rdata = 32'hCAFE;
    #1;
    chk("t6_hold", pc_hold, 1'b0);
`ifdef IFQ_BYPASS_EN
    chk("t6_byp_valid", out_valid, 1'b1);
    chk("t6_byp_instr", out_instr, 32'hCAFE);
    chk("t6_byp_pc", out_pc, 32'd215);
    tick();
    mem_ack = 1'b0;
    #1;
    chk("t6_byp_cnt", count, 3'd0);
    chk("t6_byp_after", out_valid, 1'b0);
`else
    chk("t6_noby_valid", out_valid, 1'b0);
    tick();
    mem_ack = 1'b0;
    #1;
    chk("t6_reg_valid", out_valid, 1'b1);
    chk("t6_reg_instr", out_instr, 32'hCAFE);
    chk("t6_reg_pc", out_pc, 32'd215);
    chk("t6_reg_cnt", count, 3'd1);
    tick();
    chk("t6_popped", count, 3'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
